instr_seq: RTL and testbench
============================

Name: instr_seq

Overview:
- Fetch/issue sequencer wrapped around the combinational `decode` stage.
- Fetches opcode bytes over a single-requester memory handshake, handles the 0xCB prefix, and fetches 8/16-bit immediates.
- Issues one fully decoded instruction at a time to execute, then waits for completion and an optional PC redirect.
- Owns the PC and the HALT/STOP sleep state.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- o_mem_req  out  1  byte read request
- o_mem_addr  out  16  read address (= PC)
- i_mem_ack  in  1  read complete; i_mem_rdata valid this cycle
- i_mem_rdata  in  8  read data
- o_issue_valid  out  1  decoded instruction available
- i_issue_ready  in  1  execute accepts instruction
- o_ctl_op  out  ctl_op_t  latched control op
- o_alu_op  out  alu_op_t  latched ALU op
- o_r8_sel  out  gp_r8_sel_t[0:1]  latched register selects
- o_r16_sel  out  r16_sel_t  latched 16-bit select
- o_jump_cond  out  j_cond_t  latched condition
- o_rst_tgt  out  3  latched RST target
- o_imm  out  16  immediate; 1-byte immediates zero-extended
- o_pc  out  16  current PC (address after the last fetched byte)
- i_exec_done  in  1  execute finished the issued instruction
- i_pc_load  in  1  redirect PC; sampled only with i_exec_done
- i_pc_val  in  16  redirect target
- i_wake  in  1  leave HALT/STOP
- o_halted  out  1  in sleep state
- o_instr_cnt  out  32  issued-instruction count (optional feature)
- o_stall_cnt  out  32  memory stall cycles (optional feature)

Behaviour:
- Reset:
  - state = FETCH_OP, PC = RESET_PC.
  - All outputs 0, including o_mem_req, o_issue_valid, o_imm and o_halted.
  - o_mem_req rises the first clk edge after rst deasserts.
- Memory rules:
  - o_mem_req high in FETCH_OP, FETCH_CB, IMM_LO and IMM_HI only.
  - o_mem_addr = PC, stable while req is high.
  - On each ack, PC <= PC+1, wrapping 16'hFFFF to 16'h0000.
  - Ack while req is low is ignored.
- Internal decode instance: i_is_instr16 = 1 in FETCH_CB, else 0; instr = i_mem_rdata. Decode outputs are latched on ack.
- FSM transitions:
  - FETCH_OP+ack:
    - If decode flags the 0xCB prefix -> FETCH_CB.
    - Else latch fields, clear o_imm, and branch on immediate length:
      - 1 byte: CTL_LD_R8_D8, CTL_ALU_A_D8, CTL_JR, CTL_JR_COND, CTL_LDPTR_A8_A, CTL_LDPTR_A_A8, CTL_ADD_SP_D8, CTL_LD_HL_SP_D8 -> IMM_LO.
      - 2 bytes: CTL_LD_R16_D16, CTL_LDPTR_D16_SP, CTL_JP_A16, CTL_JP_COND, CTL_CALL_A16, CTL_CALL_COND_A16, CTL_LDPTR_A16_A, CTL_LDPTR_A_A16 -> IMM_LO.
      - Otherwise -> ISSUE.
  - FETCH_CB+ack: latch fields -> ISSUE. CB ops never carry immediates.
  - IMM_LO+ack: o_imm[7:0] <= rdata; -> IMM_HI if length is 2, else ISSUE.
  - IMM_HI+ack: o_imm[15:8] <= rdata; -> ISSUE.
  - ISSUE: o_issue_valid = 1. Latched fields stay stable until valid&ready, then -> WAIT. Valid drops the cycle after the handshake.
  - WAIT, on i_exec_done:
    - If i_pc_load, PC <= i_pc_val.
    - Then -> HALT if latched ctl_op is CTL_HALT or CTL_STOP, else FETCH_OP.
  - HALT: o_halted = 1, no memory requests. On i_wake -> FETCH_OP with PC unchanged.
- Boundary cases:
  - i_pc_load without i_exec_done is ignored.
  - i_wake in the same cycle as exec_done of a HALT goes directly to FETCH_OP; o_halted never asserts.
  - i_wake outside the HALT state is ignored.
  - An immediate spanning 16'hFFFF/16'h0000 fetches from 16'h0000.
  - Asynchronous rst at any point aborts the access: req drops immediately and PC = RESET_PC.
- Latency, zero-wait memory:
  - NOP: FETCH_OP, ISSUE, WAIT = 3 cycles when ready and done are immediate.
  - Each extra byte costs 1 cycle.

Optional Feature:
- Macro: INSTR_SEQ_PERF_CNT_EN.
- Defined:
  - o_instr_cnt increments on each issue handshake.
  - o_stall_cnt increments each cycle with o_mem_req=1 and i_mem_ack=0.
  - Both are 32-bit, wrap, and reset to 0.
- Undefined: both ports are tied to 32'd0 and no counter flops are built.

Test Plan:
- Reset with RESET_PC=16'h0100; memory returns 0x00 (NOP) -> first fetch addr 16'h0100, issue after 2 cycles, o_pc=16'h0101.
- Bytes 0x01,0x34,0x12 (LD BC,d16) -> three acks, o_ctl_op=CTL_LD_R16_D16, o_imm=16'h1234, o_pc=+3.
- Bytes 0xCB,0x7C (BIT 7,H) -> o_ctl_op=CTL_ALU_R8, o_alu_op=ALU_BIT_0+7, exactly one issue.
- JR, 0x18 0xFE, at 16'hFFFE -> immediate fetched from 16'hFFFF; exec_done+pc_load with 16'hFFFE -> next fetch addr 16'hFFFE.
- 0x76 (HALT), done given, wake held low 10 cycles -> o_halted=1, o_mem_req=0 throughout; i_wake -> fetch resumes at the post-HALT PC.
- Ack delayed 3 cycles per byte, and rst asserted mid IMM_HI -> addr held stable while waiting; reset clears req, o_issue_valid and PC; with INSTR_SEQ_PERF_CNT_EN, o_stall_cnt counts 3 per byte.

Source files
------------

// File: rtl/instr_seq.sv
// instr_seq: fetch/issue sequencer around a combinational SM83-style decode.
//   Fetches opcode bytes through a single-requester byte-read handshake,
//   follows the 0xCB prefix, gathers 8/16-bit immediates, presents one
//   decoded instruction to execute, waits for completion (with an optional
//   PC redirect) and owns the HALT/STOP sleep state.
// Ports:
//   clk, rst (async, active high)
//   o_mem_req/o_mem_addr/i_mem_ack/i_mem_rdata : byte read handshake, addr = PC
//   o_issue_valid/i_issue_ready                 : issue handshake
//   o_ctl_op..o_imm                             : latched decoded instruction
//   o_pc                                        : address after last fetched byte
//   i_exec_done/i_pc_load/i_pc_val              : completion and redirect
//   i_wake/o_halted                             : sleep control
//   o_instr_cnt/o_stall_cnt                     : performance counters
// Optional feature macro: INSTR_SEQ_PERF_CNT_EN (counters built when defined,
//   otherwise both counter ports are constant zero).

typedef enum logic [5:0] {
  CTL_NOP, CTL_INVALID, CTL_HALT, CTL_STOP, CTL_DI, CTL_EI,
  CTL_LD_R8_R8, CTL_LD_R8_D8, CTL_LD_R16_D16, CTL_LD_SP_HL, CTL_LD_HL_SP_D8,
  CTL_LDPTR_R16_A, CTL_LDPTR_A_R16, CTL_LDPTR_D16_SP, CTL_LDPTR_A8_A, CTL_LDPTR_A_A8,
  CTL_LDPTR_C_A, CTL_LDPTR_A_C, CTL_LDPTR_A16_A, CTL_LDPTR_A_A16,
  CTL_INC_R8, CTL_DEC_R8, CTL_INC_R16, CTL_DEC_R16, CTL_ADD_HL_R16, CTL_ADD_SP_D8,
  CTL_ALU_A_R8, CTL_ALU_A_D8, CTL_ALU_R8, CTL_ACC_MISC,
  CTL_JR, CTL_JR_COND, CTL_JP_A16, CTL_JP_COND, CTL_JP_HL, CTL_CALL_A16, CTL_CALL_COND_A16,
  CTL_RET, CTL_RET_COND, CTL_RETI, CTL_RST, CTL_PUSH, CTL_POP
} ctl_op_t;

// Ordering matters: CB ops are computed as 8 + {x,y} of the CB opcode.
typedef enum logic [5:0] {
  ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR, ALU_CP,
  ALU_RLC, ALU_RRC, ALU_RL, ALU_RR, ALU_SLA, ALU_SRA, ALU_SWAP, ALU_SRL,
  ALU_BIT_0, ALU_BIT_1, ALU_BIT_2, ALU_BIT_3, ALU_BIT_4, ALU_BIT_5, ALU_BIT_6, ALU_BIT_7,
  ALU_RES_0, ALU_RES_1, ALU_RES_2, ALU_RES_3, ALU_RES_4, ALU_RES_5, ALU_RES_6, ALU_RES_7,
  ALU_SET_0, ALU_SET_1, ALU_SET_2, ALU_SET_3, ALU_SET_4, ALU_SET_5, ALU_SET_6, ALU_SET_7,
  ALU_DAA, ALU_CPL, ALU_SCF, ALU_CCF
} alu_op_t;

typedef enum logic [2:0] {R8_B, R8_C, R8_D, R8_E, R8_H, R8_L, R8_HL_IND, R8_A} gp_r8_sel_t;
typedef enum logic [1:0] {R16_BC, R16_DE, R16_HL, R16_SP_AF} r16_sel_t;
typedef enum logic [1:0] {J_NZ, J_Z, J_NC, J_C} j_cond_t;

module instr_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   o_mem_req,
  output logic [15:0]            o_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [7:0]             i_mem_rdata,
  output logic                   o_issue_valid,
  input  logic                   i_issue_ready,
  output ctl_op_t                o_ctl_op,
  output alu_op_t                o_alu_op,
  output gp_r8_sel_t [0:1]       o_r8_sel,
  output r16_sel_t               o_r16_sel,
  output j_cond_t                o_jump_cond,
  output logic [2:0]             o_rst_tgt,
  output logic [15:0]            o_imm,
  output logic [15:0]            o_pc,
  input  logic                   i_exec_done,
  input  logic                   i_pc_load,
  input  logic [15:0]            i_pc_val,
  input  logic                   i_wake,
  output logic                   o_halted,
  output logic [31:0]            o_instr_cnt,
  output logic [31:0]            o_stall_cnt
);

  typedef enum logic [2:0] {S_FETCH_OP, S_FETCH_CB, S_IMM_LO, S_IMM_HI, S_ISSUE, S_WAIT, S_HALT} state_t;

  typedef struct packed {
    ctl_op_t    ctl_op;
    alu_op_t    alu_op;
    gp_r8_sel_t r8_dst;
    gp_r8_sel_t r8_src;
    r16_sel_t   r16_sel;
    j_cond_t    jump_cond;
    logic [2:0] rst_tgt;
    logic       cb_prefix;
    logic [1:0] imm_len;
  } dec_t;

  // Number of immediate bytes following the opcode for each control op.
  function automatic logic [1:0] imm_bytes(input ctl_op_t op);
    case (op)
      CTL_LD_R8_D8, CTL_ALU_A_D8, CTL_JR, CTL_JR_COND, CTL_LDPTR_A8_A,
      CTL_LDPTR_A_A8, CTL_ADD_SP_D8, CTL_LD_HL_SP_D8:                      return 2'd1;
      CTL_LD_R16_D16, CTL_LDPTR_D16_SP, CTL_JP_A16, CTL_JP_COND, CTL_CALL_A16,
      CTL_CALL_COND_A16, CTL_LDPTR_A16_A, CTL_LDPTR_A_A16:                 return 2'd2;
      default:                                                             return 2'd0;
    endcase
  endfunction

  // Combinational decode stage; opcode split as x=[7:6], y=[5:3], z=[2:0].
  function automatic dec_t decode(input logic is_instr16, input logic [7:0] instr);
    dec_t d;
    logic [1:0] x;
    logic [2:0] y;
    logic [2:0] z;
    x = instr[7:6];
    y = instr[5:3];
    z = instr[2:0];
    d.ctl_op    = CTL_INVALID;
    d.alu_op    = ALU_ADD;
    d.r8_dst    = gp_r8_sel_t'(y);
    d.r8_src    = gp_r8_sel_t'(z);
    d.r16_sel   = r16_sel_t'(instr[5:4]);
    d.jump_cond = j_cond_t'(instr[4:3]);
    d.rst_tgt   = y;
    d.cb_prefix = 1'b0;
    if (is_instr16) begin
      d.ctl_op = CTL_ALU_R8;
      d.alu_op = alu_op_t'({1'b0, x, y} + 6'd8);
      d.r8_dst = gp_r8_sel_t'(z);
    end else begin
      case (x)
        2'd0: begin
          case (z)
            3'd0: begin
              case (y)
                3'd0:    d.ctl_op = CTL_NOP;
                3'd1:    d.ctl_op = CTL_LDPTR_D16_SP;
                3'd2:    d.ctl_op = CTL_STOP;
                3'd3:    d.ctl_op = CTL_JR;
                default: d.ctl_op = CTL_JR_COND;
              endcase
            end
            3'd1:    d.ctl_op = instr[3] ? CTL_ADD_HL_R16 : CTL_LD_R16_D16;
            3'd2:    d.ctl_op = instr[3] ? CTL_LDPTR_A_R16 : CTL_LDPTR_R16_A;
            3'd3:    d.ctl_op = instr[3] ? CTL_DEC_R16 : CTL_INC_R16;
            3'd4:    d.ctl_op = CTL_INC_R8;
            3'd5:    d.ctl_op = CTL_DEC_R8;
            3'd6:    d.ctl_op = CTL_LD_R8_D8;
            default: begin
              // RLCA..RRA map onto the rotates, DAA..CCF onto their own ops
              d.ctl_op = CTL_ACC_MISC;
              d.alu_op = alu_op_t'(y[2] ? (6'd40 + {4'd0, y[1:0]}) : (6'd8 + {4'd0, y[1:0]}));
            end
          endcase
        end
        2'd1: d.ctl_op = (instr == 8'h76) ? CTL_HALT : CTL_LD_R8_R8;
        2'd2: begin
          d.ctl_op = CTL_ALU_A_R8;
          d.alu_op = alu_op_t'({3'd0, y});
          d.r8_dst = R8_A;
        end
        default: begin
          case (z)
            3'd0: begin
              case (y)
                3'd4:    d.ctl_op = CTL_LDPTR_A8_A;
                3'd5:    d.ctl_op = CTL_ADD_SP_D8;
                3'd6:    d.ctl_op = CTL_LDPTR_A_A8;
                3'd7:    d.ctl_op = CTL_LD_HL_SP_D8;
                default: d.ctl_op = CTL_RET_COND;
              endcase
            end
            3'd1: begin
              if (!instr[3]) begin
                d.ctl_op = CTL_POP;
              end else begin
                case (instr[5:4])
                  2'd0:    d.ctl_op = CTL_RET;
                  2'd1:    d.ctl_op = CTL_RETI;
                  2'd2:    d.ctl_op = CTL_JP_HL;
                  default: d.ctl_op = CTL_LD_SP_HL;
                endcase
              end
            end
            3'd2: begin
              case (y)
                3'd4:    d.ctl_op = CTL_LDPTR_C_A;
                3'd5:    d.ctl_op = CTL_LDPTR_A16_A;
                3'd6:    d.ctl_op = CTL_LDPTR_A_C;
                3'd7:    d.ctl_op = CTL_LDPTR_A_A16;
                default: d.ctl_op = CTL_JP_COND;
              endcase
            end
            3'd3: begin
              case (y)
                3'd0:    d.ctl_op = CTL_JP_A16;
                3'd1: begin
                  d.ctl_op    = CTL_NOP;
                  d.cb_prefix = 1'b1;
                end
                3'd6:    d.ctl_op = CTL_DI;
                3'd7:    d.ctl_op = CTL_EI;
                default: d.ctl_op = CTL_INVALID;
              endcase
            end
            3'd4:    d.ctl_op = y[2] ? CTL_INVALID : CTL_CALL_COND_A16;
            3'd5:    d.ctl_op = !instr[3] ? CTL_PUSH : ((y == 3'd1) ? CTL_CALL_A16 : CTL_INVALID);
            3'd6: begin
              d.ctl_op = CTL_ALU_A_D8;
              d.alu_op = alu_op_t'({3'd0, y});
              d.r8_dst = R8_A;
            end
            default: d.ctl_op = CTL_RST;
          endcase
        end
      endcase
    end
    d.imm_len = imm_bytes(d.ctl_op);
    return d;
  endfunction

  state_t      state;
  logic [15:0] pc;
  logic [1:0]  imm_len;
  logic        mem_fire;
  dec_t        dec;

  // Decode the byte on the read bus; CB-page only while fetching the second byte.
  always_comb begin
    dec      = decode(state == S_FETCH_CB, i_mem_rdata);
    mem_fire = o_mem_req & i_mem_ack;
  end

  assign o_mem_addr = pc;
  assign o_pc       = pc;

  // Sequencer FSM: PC, request, issue and sleep control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FETCH_OP;
      pc            <= RESET_PC;
      o_mem_req     <= 1'b0;
      o_issue_valid <= 1'b0;
      o_halted      <= 1'b0;
      o_imm         <= 16'h0000;
      imm_len       <= 2'd0;
    end else begin
      if (mem_fire) pc <= pc + 16'd1;
      case (state)
        S_FETCH_OP: begin
          // Req is low only in the first cycle after reset
          o_mem_req <= 1'b1;
          if (mem_fire) begin
            if (dec.cb_prefix) begin
              state <= S_FETCH_CB;
            end else begin
              o_imm   <= 16'h0000;
              imm_len <= dec.imm_len;
              if (dec.imm_len != 2'd0) begin
                state <= S_IMM_LO;
              end else begin
                state         <= S_ISSUE;
                o_mem_req     <= 1'b0;
                o_issue_valid <= 1'b1;
              end
            end
          end
        end
        S_FETCH_CB: begin
          if (mem_fire) begin
            state         <= S_ISSUE;
            o_mem_req     <= 1'b0;
            o_issue_valid <= 1'b1;
          end
        end
        S_IMM_LO: begin
          if (mem_fire) begin
            o_imm[7:0] <= i_mem_rdata;
            if (imm_len == 2'd2) begin
              state <= S_IMM_HI;
            end else begin
              state         <= S_ISSUE;
              o_mem_req     <= 1'b0;
              o_issue_valid <= 1'b1;
            end
          end
        end
        S_IMM_HI: begin
          if (mem_fire) begin
            o_imm[15:8]   <= i_mem_rdata;
            state         <= S_ISSUE;
            o_mem_req     <= 1'b0;
            o_issue_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (i_issue_ready) begin
            o_issue_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_exec_done) begin
            if (i_pc_load) pc <= i_pc_val;
            // A wake arriving with completion skips the sleep state entirely
            if ((o_ctl_op == CTL_HALT || o_ctl_op == CTL_STOP) && !i_wake) begin
              state    <= S_HALT;
              o_halted <= 1'b1;
            end else begin
              state     <= S_FETCH_OP;
              o_mem_req <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (i_wake) begin
            state     <= S_FETCH_OP;
            o_halted  <= 1'b0;
            o_mem_req <= 1'b1;
          end
        end
        default: begin
          state         <= S_FETCH_OP;
          o_mem_req     <= 1'b0;
          o_issue_valid <= 1'b0;
          o_halted      <= 1'b0;
        end
      endcase
    end
  end

  // Capture decoded fields on the ack that completes the opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ctl_op    <= CTL_NOP;
      o_alu_op    <= ALU_ADD;
      o_r8_sel[0] <= R8_B;
      o_r8_sel[1] <= R8_B;
      o_r16_sel   <= R16_BC;
      o_jump_cond <= J_NZ;
      o_rst_tgt   <= 3'd0;
    end else if (mem_fire && ((state == S_FETCH_OP && !dec.cb_prefix) || state == S_FETCH_CB)) begin
      o_ctl_op    <= dec.ctl_op;
      o_alu_op    <= dec.alu_op;
      o_r8_sel[0] <= dec.r8_dst;
      o_r8_sel[1] <= dec.r8_src;
      o_r16_sel   <= dec.r16_sel;
      o_jump_cond <= dec.jump_cond;
      o_rst_tgt   <= dec.rst_tgt;
    end
  end

`ifdef INSTR_SEQ_PERF_CNT_EN
  logic [31:0] instr_cnt;
  logic [31:0] stall_cnt;

  // Issue handshakes and request cycles without an ack, both wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (o_issue_valid && i_issue_ready) instr_cnt <= instr_cnt + 32'd1;
      if (o_mem_req && !i_mem_ack)        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign o_instr_cnt = instr_cnt;
  assign o_stall_cnt = stall_cnt;
`else
  assign o_instr_cnt = 32'd0;
  assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_seq.sv
// Directed testbench for instr_seq with a byte memory responder whose ack
// latency is programmable (ack_delay cycles of stall per byte).
module tb_instr_seq;

  logic             clk;
  logic             rst;
  logic             mem_req;
  logic [15:0]      mem_addr;
  logic             mem_ack;
  logic [7:0]       mem_rdata;
  logic             issue_valid;
  logic             issue_ready;
  ctl_op_t          ctl_op;
  alu_op_t          alu_op;
  gp_r8_sel_t [0:1] r8_sel;
  r16_sel_t         r16_sel;
  j_cond_t          jump_cond;
  logic [2:0]       rst_tgt;
  logic [15:0]      imm;
  logic [15:0]      pc;
  logic             exec_done;
  logic             pc_load;
  logic [15:0]      pc_val;
  logic             wake;
  logic             halted;
  logic [31:0]      instr_cnt;
  logic [31:0]      stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:65535];
  int         ack_delay;
  int         wcnt;

  instr_seq #(.RESET_PC(16'h0100)) dut (
    .clk(clk), .rst(rst),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_issue_valid(issue_valid), .i_issue_ready(issue_ready),
    .o_ctl_op(ctl_op), .o_alu_op(alu_op), .o_r8_sel(r8_sel), .o_r16_sel(r16_sel),
    .o_jump_cond(jump_cond), .o_rst_tgt(rst_tgt), .o_imm(imm), .o_pc(pc),
    .i_exec_done(exec_done), .i_pc_load(pc_load), .i_pc_val(pc_val),
    .i_wake(wake), .o_halted(halted), .o_instr_cnt(instr_cnt), .o_stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: ack once the request has waited ack_delay cycles.
  always_comb begin
    mem_ack   = mem_req && (wcnt >= ack_delay);
    mem_rdata = mem[mem_addr];
  end

  always @(posedge clk or posedge rst) begin
    if (rst)                   wcnt <= 0;
    else if (!mem_req || mem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!issue_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
  endtask

  // Handshake, one WAIT cycle with stray redirect/wake, then completion.
  task automatic finish_instr(input logic ld, input logic [15:0] val, input logic wk);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("valid_drop", 32'(issue_valid), 32'd0);
    pc_load = 1'b1;
    pc_val  = 16'h5555;
    wake    = 1'b1;
    tick();
    chk("stray_wake", 32'(halted), 32'd0);
    pc_load   = ld;
    pc_val    = val;
    wake      = wk;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    pc_load   = 1'b0;
    wake      = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; issue_ready = 1'b0; exec_done = 1'b0; pc_load = 1'b0;
    pc_val = 16'h0000; wake = 1'b0; ack_delay = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0101] = 8'h01; mem[16'h0102] = 8'h34; mem[16'h0103] = 8'h12;
    mem[16'h0104] = 8'hCB; mem[16'h0105] = 8'h7C;
    mem[16'h0106] = 8'h76; mem[16'h0107] = 8'h76;
    mem[16'h0108] = 8'h3E; mem[16'h0109] = 8'h5A;
    mem[16'hFFFE] = 8'h18; mem[16'hFFFF] = 8'hFE; mem[16'h0000] = 8'h42;

    // Reset state
    repeat (2) tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0100);
    chk("rst_ctl", 32'(ctl_op), 32'(CTL_NOP));
    chk("rst_icnt", instr_cnt, 32'd0);
    rst = 1'b0;
    tick();
    chk("req_rise", 32'(mem_req), 32'd1);
    chk("addr0", 32'(mem_addr), 32'h0100);

    // NOP
    wait_valid("nop", n);
    chk("nop_lat", n, 32'd1);
    chk("nop_ctl", 32'(ctl_op), 32'(CTL_NOP));
    chk("nop_pc", 32'(pc), 32'h0101);
    chk("nop_req", 32'(mem_req), 32'd0);
    tick();
    chk("valid_hold", 32'(issue_valid), 32'd1);
    finish_instr(1'b0, 16'h0000, 1'b0);
    chk("ldbc_addr", 32'(mem_addr), 32'h0101);

    // LD BC,d16
    wait_valid("ldbc", n);
    chk("ldbc_lat", n, 32'd3);
    chk("ldbc_ctl", 32'(ctl_op), 32'(CTL_LD_R16_D16));
    chk("ldbc_r16", 32'(r16_sel), 32'(R16_BC));
    chk("ldbc_imm", 32'(imm), 32'h1234);
    chk("ldbc_pc", 32'(pc), 32'h0104);
    finish_instr(1'b0, 16'h0000, 1'b0);
    chk("cb_addr", 32'(mem_addr), 32'h0104);

    // CB 7C: BIT 7,H
    wait_valid("cb", n);
    chk("cb_lat", n, 32'd2);
    chk("cb_ctl", 32'(ctl_op), 32'(CTL_ALU_R8));
    chk("cb_alu", 32'(alu_op), 32'(ALU_BIT_7));
    chk("cb_r8", 32'(r8_sel[0]), 32'(R8_H));
    chk("cb_pc", 32'(pc), 32'h0106);
    finish_instr(1'b0, 16'h0000, 1'b0);
    chk("cb_once", 32'(mem_addr), 32'h0106);

    // HALT with a long sleep
    wait_valid("halt", n);
    chk("halt_ctl", 32'(ctl_op), 32'(CTL_HALT));
    finish_instr(1'b0, 16'h0000, 1'b0);
    chk("halt_in", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_sleep", {30'd0, halted, mem_req}, 32'd2);
    end
    wake = 1'b1;
    tick();
    wake = 1'b0;
    chk("wake_halted", 32'(halted), 32'd0);
    chk("wake_req", 32'(mem_req), 32'd1);
    chk("wake_addr", 32'(mem_addr), 32'h0107);

    // HALT with wake arriving together with completion
    wait_valid("halt2", n);
    finish_instr(1'b0, 16'h0000, 1'b1);
    chk("halt2_halted", 32'(halted), 32'd0);
    chk("halt2_req", 32'(mem_req), 32'd1);
    chk("halt2_addr", 32'(mem_addr), 32'h0108);

    // LD A,d8 then redirect to 0xFFFE
    wait_valid("lda", n);
    chk("lda_lat", n, 32'd2);
    chk("lda_ctl", 32'(ctl_op), 32'(CTL_LD_R8_D8));
    chk("lda_r8", 32'(r8_sel[0]), 32'(R8_A));
    chk("lda_imm", 32'(imm), 32'h005A);
    finish_instr(1'b1, 16'hFFFE, 1'b0);
    chk("jr_addr", 32'(mem_addr), 32'hFFFE);

    // JR at 0xFFFE, offset byte at 0xFFFF
    wait_valid("jr", n);
    chk("jr_ctl", 32'(ctl_op), 32'(CTL_JR));
    chk("jr_imm", 32'(imm), 32'h00FE);
    chk("jr_pc", 32'(pc), 32'h0000);
    finish_instr(1'b1, 16'hFFFE, 1'b0);
    chk("jr_redir", 32'(mem_addr), 32'hFFFE);
    wait_valid("jr2", n);
    finish_instr(1'b1, 16'hFFFF, 1'b0);

    // CP d8 at 0xFFFF, immediate wraps to 0x0000
    wait_valid("cp", n);
    chk("cp_ctl", 32'(ctl_op), 32'(CTL_ALU_A_D8));
    chk("cp_alu", 32'(alu_op), 32'(ALU_CP));
    chk("cp_imm", 32'(imm), 32'h0042);
    chk("cp_pc", 32'(pc), 32'h0001);
    finish_instr(1'b1, 16'h0101, 1'b0);
`ifdef INSTR_SEQ_PERF_CNT_EN
    chk("icnt", instr_cnt, 32'd9);
    chk("scnt0", stall_cnt, 32'd0);
`else
    chk("icnt_off", instr_cnt, 32'd0);
    chk("scnt_off", stall_cnt, 32'd0);
`endif

    // Slow memory: 3 stall cycles per byte, reset during IMM_HI
    ack_delay = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("slow_op_addr", 32'(mem_addr), 32'h0101);
    end
    tick();
    chk("slow_lo_addr", 32'(mem_addr), 32'h0102);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("slow_lo_hold", 32'(mem_addr), 32'h0102);
    end
    tick();
    chk("slow_hi_addr", 32'(mem_addr), 32'h0103);
    tick();
`ifdef INSTR_SEQ_PERF_CNT_EN
    chk("scnt_slow", stall_cnt, 32'd7);
`else
    chk("scnt_slow_off", stall_cnt, 32'd0);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_valid", 32'(issue_valid), 32'd0);
    chk("arst_pc", 32'(pc), 32'h0100);
    chk("arst_icnt", instr_cnt, 32'd0);
    chk("arst_scnt", stall_cnt, 32'd0);
    tick();
    rst = 1'b0;
    ack_delay = 0;
    tick();
    chk("rerun_req", 32'(mem_req), 32'd1);
    chk("rerun_addr", 32'(mem_addr), 32'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
